uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
Serial transmitter that consumes the register block's TX-side outputs (tx_data_out, start_tx, cfg_reg_out) and drives the UART TX line.
- Frame: start bit, 5-8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
- Produces the one-cycle done pulse that feeds the register block's set_tx_done input.
- Contains an internal bit-period (baud) divider; no external baud tick.

Parameters:
BAUD_DIV, 434, pclk cycles per serial bit (434 gives 115200 baud at 50 MHz); legal range 2..65535.

Ports:
pclk  input  1  APB/system clock; all logic is on the rising edge.
presetn  input  1  Asynchronous, active-low reset.
tx_data  input  8  Byte to send; only the low N bits are used (N = configured data width).
start_tx  input  1  Level from the control register; a rising edge requests one frame.
cfg  input  5  [1:0] data bits (00=5, 01=6, 10=7, 11=8); [2] stop bits (0=1, 1=2); [3] parity_en; [4] parity_type (0=even, 1=odd).
tx  output  1  Serial line; idles high.
tx_busy  output  1  High from the first start-bit cycle through the last stop-bit cycle.
tx_done  output  1  One-cycle pulse at frame completion; connects to set_tx_done.

Behaviour:
- Reset (asynchronous, presetn low):
  - tx=1, tx_busy=0, tx_done=0.
  - FSM returns to IDLE; bit counter, baud counter and start_q clear to 0.
  - Reset asserted mid-frame aborts the frame: tx returns high at once and no tx_done is issued.
- Start edge detect:
  - start_q registers start_tx every cycle, including while busy.
  - rise = start_tx & ~start_q.
  - A rise seen while not in IDLE is dropped, not queued.
  - A start_tx held high produces exactly one frame.
- Launch: when rise is sampled in IDLE at edge k:
  - tx_data, the decoded data-bit count and the cfg fields are latched into a shadow register.
  - tx goes low and tx_busy goes high at edge k (visible in cycle k+1).
  - Changing tx_data or cfg mid-frame has no effect on the current frame.
- FSM states: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE.
  - Each bit occupies exactly BAUD_DIV cycles, timed by a baud counter that counts 0..BAUD_DIV-1.
  - A state advances when the counter reaches BAUD_DIV-1; the counter then wraps to 0.
- DATA:
  - Shift register outputs bit0 first.
  - Bit index counts 0..N-1, where N = 5 + cfg[1:0].
  - Leave DATA after index N-1 completes.
- PARITY: drive p = XOR(data[N-1:0]) XOR parity_type.
  - Even parity: total ones in data plus parity bit is even.
  - Odd parity: that total is odd.
- STOP:
  - tx=1 for 1 or 2 bit periods.
  - The stop counter reuses the bit index register.
- Completion:
  - At the edge ending the final stop period: state->IDLE, tx_busy->0, tx_done->1 for exactly one cycle.
  - Frame length = BAUD_DIV*(1+N+parity_en+1+stop2) cycles from the launch edge to the tx_done edge.
- Back-to-back: a rise that arrives in the same cycle the FSM enters IDLE is sampled on the next edge and starts a new frame; the idle gap is at least one cycle.
- tx is registered; no combinational path from any input to any output.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - cfg field index constants (CFG_DBITS_LSB=0, CFG_STOP=2, CFG_PAR_EN=3, CFG_PAR_ODD=4).
  - Function mapping data-bit code to count.
  - The package is also used by the future uart_rx_core.
- One natural sub-module: uart_baud_gen.
  - Parameterised by BAUD_DIV.
  - Counter with sync clear and an enable input; outputs bit_tick when the count equals BAUD_DIV-1.
  - uart_rx_core reuses it.

Test Plan:
All scenarios use BAUD_DIV=4.
1. cfg=5'b00011 (8N1), tx_data=8'h55, start_tx 0->1 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; tx_busy high 40 cycles; tx_done single pulse 40 cycles after launch edge.
2. cfg=5'b01110 (7 data, even parity, 2 stop), tx_data=8'hDA -> data bits 0,1,0,1,1,0,1 (8'h5A, popcount 4), parity 0, two stop bits; frame 44 cycles.
3. cfg=5'b11000 (5 data, odd parity, 1 stop), tx_data=8'hFF -> five 1s, parity bit 0; frame 32 cycles; upper bits ignored.
4. During scenario 1, at cycle 15: toggle start_tx 0->1 and change tx_data to 8'h00 and cfg to 5'b00000 -> waveform identical to scenario 1, exactly one tx_done, no second frame.
5. presetn pulsed low at cycle 20 of an 8N1 frame -> tx=1, tx_busy=0 immediately and asynchronously; no tx_done; a new rise after release sends a clean frame.
6. start_tx held high for 200 cycles -> exactly one frame and one tx_done; then low->high again -> second frame starts one cycle after the edge is sampled.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, cfg field positions and frame shadow layout.
// Used by the TX core and the upcoming RX core.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CFG_W  = 5;
  localparam int unsigned IDX_W  = 3;

  localparam int unsigned CFG_DBITS_LSB = 0;
  localparam int unsigned CFG_STOP      = 2;
  localparam int unsigned CFG_PAR_EN    = 3;
  localparam int unsigned CFG_PAR_ODD   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Per-frame settings captured at launch so cfg/data changes mid-frame are ignored.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  last_idx;
    logic              stop2;
    logic              par_en;
    logic              par_bit;
  } uart_frame_t;

  // Data-bit code 00..11 maps to 5..8 bits.
  function automatic logic [3:0] dbits_count(input logic [1:0] code);
    return 4'(4'd5 + {2'b00, code});
  endfunction

  // Mask selecting the low N data bits for a given code.
  function automatic logic [DATA_W-1:0] dbits_mask(input logic [1:0] code);
    return DATA_W'(8'hFF >> (2'd3 - code));
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled, bit_tick is high on the last count.
// bit_tick is kept as a flop that tracks (count == BAUD_DIV-1) so it carries no decode logic.
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q    <= '0;
      bit_tick <= 1'b0;
    end else if (clr) begin
      cnt_q    <= '0;
      bit_tick <= 1'b0;
    end else if (en) begin
      if (bit_tick) begin
        cnt_q    <= '0;
        bit_tick <= 1'b0;
      end else begin
        cnt_q    <= cnt_inc;
        bit_tick <= (cnt_inc == CNT_LAST);
      end
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Launches on a rising edge of start_tx seen in IDLE; tx_done pulses once per completed frame.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start_tx,
  input  logic [CFG_W-1:0]  cfg,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  uart_state_e       state_q, state_d;
  uart_frame_t       frame_q, frame_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              start_q;
  logic              start_rise;
  logic              bit_tick;
  logic              tx_d, busy_d, done_d;
  logic [1:0]        dbits_code;

  assign start_rise = start_tx & ~start_q;
  assign dbits_code = cfg[CFG_DBITS_LSB +: 2];

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .pclk     (pclk),
    .presetn  (presetn),
    .clr      (state_q == IDLE),
    .en       (state_q != IDLE),
    .bit_tick (bit_tick)
  );

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus shadow/shift/index updates
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d          = START;
          idx_d            = '0;
          frame_d.data     = tx_data;
          frame_d.last_idx = IDX_W'(dbits_count(dbits_code) - 4'd1);
          frame_d.stop2    = cfg[CFG_STOP];
          frame_d.par_en   = cfg[CFG_PAR_EN];
          frame_d.par_bit  = (^(tx_data & dbits_mask(dbits_code))) ^ cfg[CFG_PAR_ODD];
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          frame_d.data = {1'b0, frame_q.data[DATA_W-1:1]};
          if (idx_q == frame_q.last_idx) begin
            idx_d   = '0;
            state_d = frame_q.par_en ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        // Second stop period reuses the bit index as its counter.
        if (bit_tick) begin
          if (frame_q.stop2 && (idx_q == '0)) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame_d.data[0];
      PARITY:  tx_d = frame_d.par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      start_q <= 1'b0;
      idx_q   <= '0;
      frame_q <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      start_q <= start_tx;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frame table, corner sequences and
// random frames compared against a bit-list reference model of the serial frame.
module tb_uart_tx_core;

  localparam int unsigned BAUD_DIV = 4;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [7:0] tx_data;
  logic       start_tx;
  logic [4:0] cfg;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0]  data;
    logic [4:0]  cfg;
    logic [11:0] vec;
    int          nb;
    bit          disturb;
  } vec_t;

  vec_t tbl[4];

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .tx_data  (tx_data),
    .start_tx (start_tx),
    .cfg      (cfg),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (presetn && tx_done) done_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: list of serial bit values, one entry per bit period.
  function automatic void model_frame(input logic [7:0] d, input logic [4:0] c,
                                      output logic [11:0] v, output int nb);
    int n;
    int ones;
    int idx;
    n    = 5 + int'(c[1:0]);
    v    = '0;
    ones = 0;
    idx  = 1;
    for (int i = 0; i < n; i++) begin
      v[idx] = d[i];
      ones  += int'(d[i]);
      idx++;
    end
    if (c[3]) begin
      v[idx] = ((ones % 2) == 1) ^ c[4];
      idx++;
    end
    v[idx] = 1'b1;
    idx++;
    if (c[2]) begin
      v[idx] = 1'b1;
      idx++;
    end
    nb = idx;
  endfunction

  task automatic launch(input logic [7:0] d, input logic [4:0] c);
    start_tx = 1'b0;
    tx_data  = d;
    cfg      = c;
    @(posedge pclk);
    #1;
    start_tx = 1'b1;
  endtask

  // Checks one frame whose launch edge is the next rising edge.
  task automatic check_frame(input string tag, input logic [11:0] vec, input int nb,
                             input bit disturb, input bit chain,
                             input logic [7:0] nd, input logic [4:0] nc);
    int len;
    int d0;
    len = nb * int'(BAUD_DIV);
    d0  = done_cnt;
    for (int j = 0; j < len; j++) begin
      @(posedge pclk);
      #1;
      if (j == 0) d0 = done_cnt;
      chk({tag, " tx"}, int'(tx), int'(vec[j / int'(BAUD_DIV)]));
      chk({tag, " busy"}, int'(tx_busy), 1);
      if (disturb && j == 14) start_tx = 1'b0;
      if (disturb && j == 15) begin
        start_tx = 1'b1;
        tx_data  = 8'h00;
        cfg      = 5'b00000;
      end
      if (chain && j == len - 1) begin
        start_tx = 1'b0;
        tx_data  = nd;
        cfg      = nc;
      end
    end
    @(posedge pclk);
    #1;
    chk({tag, " end tx"}, int'(tx), 1);
    chk({tag, " end busy"}, int'(tx_busy), 0);
    chk({tag, " done pulse"}, int'(tx_done), 1);
    if (chain) begin
      start_tx = 1'b1;
    end else begin
      @(posedge pclk);
      #1;
      chk({tag, " done width"}, int'(tx_done), 0);
      chk({tag, " done count"}, done_cnt - d0, 1);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int d0;
    d0 = done_cnt;
    for (int j = 0; j < n; j++) begin
      @(posedge pclk);
      #1;
      chk({tag, " idle tx"}, int'(tx), 1);
      chk({tag, " idle busy"}, int'(tx_busy), 0);
    end
    chk({tag, " idle no done"}, done_cnt - d0, 0);
  endtask

  initial begin
    logic [11:0] v, v2, v3;
    int          nb, nb2, nb3;
    logic [7:0]  d, d2, d3;
    logic [4:0]  c, c2, c3;

    tbl[0] = '{8'h55, 5'b00011, 12'h2AA, 10, 1'b0};
    tbl[1] = '{8'hDA, 5'b01110, 12'h6B4, 11, 1'b0};
    tbl[2] = '{8'hFF, 5'b11000, 12'h0BE,  8, 1'b0};
    tbl[3] = '{8'h55, 5'b00011, 12'h2AA, 10, 1'b1};

    presetn  = 1'b0;
    start_tx = 1'b0;
    tx_data  = 8'h00;
    cfg      = 5'b00000;
    #12;
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(tx_busy), 0);
    chk("reset done", int'(tx_done), 0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (3) @(posedge pclk);

    // Directed frames, including a mid-frame restart/data/cfg disturbance
    for (int i = 0; i < 4; i++) begin
      launch(tbl[i].data, tbl[i].cfg);
      check_frame($sformatf("vec%0d", i), tbl[i].vec, tbl[i].nb, tbl[i].disturb, 1'b0, 8'h00, 5'b0);
      idle_check($sformatf("vec%0d", i), 20);
    end

    // Reset mid-frame aborts without tx_done
    launch(8'h00, 5'b00011);
    repeat (21) @(posedge pclk);
    #1;
    chk("abort pre busy", int'(tx_busy), 1);
    chk("abort pre tx", int'(tx), 0);
    start_tx = 1'b0;
    presetn  = 1'b0;
    #1;
    chk("abort tx", int'(tx), 1);
    chk("abort busy", int'(tx_busy), 0);
    chk("abort done", int'(tx_done), 0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    idle_check("post abort", 50);
    d = 8'($urandom);
    model_frame(d, 5'b00011, v, nb);
    launch(d, 5'b00011);
    check_frame("post abort frame", v, nb, 1'b0, 1'b0, 8'h00, 5'b0);

    // start_tx held high: one frame only, then a fresh edge relaunches
    d = 8'($urandom);
    model_frame(d, 5'b00011, v, nb);
    launch(d, 5'b00011);
    check_frame("held", v, nb, 1'b0, 1'b0, 8'h00, 5'b0);
    idle_check("held", 155);
    d = 8'($urandom);
    c = 5'($urandom);
    model_frame(d, c, v, nb);
    launch(d, c);
    check_frame("held relaunch", v, nb, 1'b0, 1'b0, 8'h00, 5'b0);

    // Back-to-back: rise lands in the cycle the FSM returns to IDLE
    d  = 8'($urandom); c  = 5'($urandom);
    d2 = 8'($urandom); c2 = 5'($urandom);
    d3 = 8'($urandom); c3 = 5'($urandom);
    model_frame(d, c, v, nb);
    model_frame(d2, c2, v2, nb2);
    model_frame(d3, c3, v3, nb3);
    launch(d, c);
    check_frame("b2b0", v, nb, 1'b0, 1'b1, d2, c2);
    check_frame("b2b1", v2, nb2, 1'b0, 1'b1, d3, c3);
    check_frame("b2b2", v3, nb3, 1'b0, 1'b0, 8'h00, 5'b0);

    // Random frames against the reference model
    for (int r = 0; r < 20; r++) begin
      d = 8'($urandom);
      c = 5'($urandom);
      model_frame(d, c, v, nb);
      launch(d, c);
      check_frame($sformatf("rand%0d", r), v, nb, 1'b0, 1'b0, 8'h00, 5'b0);
      idle_check($sformatf("rand%0d", r), int'($urandom_range(1, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
